pe_issue_tracker: RTL
=====================

# pe_issue_tracker

Synthesizable issuer side of the instruction-scheduler to PE interface. It accepts PE instructions tagged with an ID from the scheduler and drives them onto the PE `pe_insn/pe_vld/pe_rdy` handshake through one output register. It tracks every issued instruction through its two in-order completion pulses, `pe_rd_ack` then `pe_wr_ack`, and reports the ID of each completion back to the scheduler. It limits in-flight work to `MAX_INFLIGHT` and flags protocol violations.

## Interface
- `INSN_W`, default `PE_INST_W`: instruction width.
- `ID_W`, default 4: scheduler tag width.
- `MAX_INFLIGHT`, default 16: maximum instructions between acceptance and `wr_ack`. Must be a power of 2 and at least 2.

Ports:
- `clk` in 1: clock.
- `s_rst` in 1: reset. One clock; reset is synchronous and active-high.
- `in_insn` in `INSN_W`: instruction from the scheduler.
- `in_id` in `ID_W`: tag of `in_insn`.
- `in_vld` in 1 / `in_rdy` out 1: scheduler-side handshake.
- `pe_insn` out `INSN_W`: instruction to the PE.
- `pe_vld` out 1 / `pe_rdy` in 1: PE-side handshake.
- `pe_rd_ack` in 1: one-cycle pulse; the oldest rd-pending instruction has released its read resources.
- `pe_wr_ack` in 1: one-cycle pulse; the oldest wr-pending instruction has completed.
- `rd_done_vld` out 1, `rd_done_id` out `ID_W`: pulse carrying the ID of the read-released instruction.
- `wr_done_vld` out 1, `wr_done_id` out `ID_W`: pulse carrying the ID of the completed instruction.
- `inflight_cnt` out `$clog2(MAX_INFLIGHT)+1`: staged plus rd-pending plus wr-pending count.
- `idle` out 1: `inflight_cnt == 0`.
- `err_ack` out 1: sticky; set by an illegal ack.

## Operation
- Output stage: a single register holding `pe_insn`, its ID and `pe_vld`.
  - It loads on `in_vld && in_rdy`.
  - It clears when `pe_vld && pe_rdy` and no new load occurs in the same cycle.
  - `pe_insn` is stable while `pe_vld && !pe_rdy`.
- `in_rdy = (!pe_vld || pe_rdy) && (inflight_cnt < MAX_INFLIGHT)`. This is combinational from registers and `pe_rdy` only; there is no path from `in_vld`.
- ID ring: depth `MAX_INFLIGHT`, three pointers of width `$clog2(MAX_INFLIGHT)+1` with the wrap bit.
  - `iss_ptr`: writes the staged ID on the PE handshake.
  - `rd_ptr`: advances on a legal `pe_rd_ack`.
  - `wr_ptr`: advances on a legal `pe_wr_ack`.
- Derived counts:
  - `n_rd = iss_ptr - rd_ptr`
  - `n_wr = rd_ptr - wr_ptr`
  - `inflight_cnt = (iss_ptr - wr_ptr) + pe_vld`
- Each instruction moves through four states: staged, then rd-pending, then wr-pending, then retired. These states are implied by the pointers; no explicit FSM is required.
- Legality rules:
  - `pe_rd_ack` is legal iff `n_rd > 0` at the start of the cycle.
  - `pe_wr_ack` is legal iff `n_wr > 0` at the start of the cycle.
  - An ack for an instruction handed over in the same cycle is illegal, and so is a `wr_ack` in the same cycle as its own `rd_ack`.
  - An illegal ack is ignored: no pointer move, no done pulse. It sets `err_ack`, which is cleared only by reset.
- `pe_rd_ack` and `pe_wr_ack` may assert in the same cycle (different instructions). Both are processed.
- Ring full cannot occur while `in_rdy` obeys the limit: the staged slot is counted in `inflight_cnt`.

## Timing
- Reset values, the cycle after `s_rst` is sampled high:
  - `pe_vld=0`, `rd_done_vld=0`, `wr_done_vld=0`, `err_ack=0`, `inflight_cnt=0`.
  - `idle=1`, `in_rdy=1`.
  - All pointers are 0.
  - The staged instruction is discarded.
- Reset mid-operation drops every pending instruction with no done pulses.
- Latency from `in_vld && in_rdy` at cycle N to `pe_vld` is cycle N+1.
- Back-to-back throughput: one instruction per cycle while `pe_rdy=1` and the in-flight limit is not reached.
- `rd_done_vld` and `wr_done_vld` are registered: they assert in cycle N+1 for a legal ack sampled in cycle N, are 1 cycle wide, and carry the ring entry read at that ack.
- `inflight_cnt` and `idle` reflect the register state; they update the cycle after a handshake or ack.
- Pointer wrap: the ring index is `ptr[$clog2(MAX_INFLIGHT)-1:0]`. Counts use modulo subtraction over the full width.

## Structure
- Types and constants go in `instruction_scheduler_pkg`:
  - `pe_issue_id_t`
  - localparam `PE_INFLIGHT_W`
  - a function `ptr_diff` shared by all three counts.
- `PE_INST_W` comes from `hpu_common_instruction_pkg`.
- Sub-module `pe_issue_id_ring`: register array with one write port and two asynchronous read ports (`rd_ptr`, `wr_ptr`), plus the pointer logic.
- The top level holds the output stage, the legality checks and the done registers.

## Test plan
- **Single instruction:** `pe_rdy=1`; one instruction with ID 5 is accepted at cycle 0, `pe_rd_ack` arrives at cycle 3 and `pe_wr_ack` at cycle 6.
  - `pe_vld` asserts at cycle 1.
  - `rd_done_id=5` at cycle 4.
  - `wr_done_id=5` at cycle 7.
  - `idle=1` at cycle 7.
- **Back-pressure:** `pe_rdy=0` for 5 cycles.
  - At most one instruction is staged.
  - `pe_insn` holds constant.
  - `in_rdy=0` until `pe_rdy` rises.
- **In-flight limit:** `MAX_INFLIGHT=16`, 20 IDs offered, no acks.
  - Exactly 16 are accepted (15 issued plus 1 staged) and `in_rdy` stays 0.
  - One rd/wr ack pair lets the 17th through.
  - IDs wrap correctly over 40 instructions.
- **Simultaneous acks:** IDs 1 and 2 outstanding, ID 1 rd-released; `pe_wr_ack` and `pe_rd_ack` pulse in the same cycle.
  - `wr_done_id=1` and `rd_done_id=2` in the same cycle.
  - `err_ack=0`.
- **Illegal ack:** `pe_wr_ack` while `n_wr=0`.
  - `err_ack=1` and stays set.
  - No `wr_done_vld`.
  - Counts unchanged.
- **Reset mid-stream:** `s_rst` pulsed high for 1 cycle with 3 instructions in flight.
  - All outputs at their reset values.
  - A subsequent instruction with ID 9 completes normally.

Source files
------------

// File: rtl/hpu_common_instruction_pkg.sv
// Instruction-format constants shared across the HPU blocks.
package hpu_common_instruction_pkg;
  localparam int PE_INST_W = 32;
endpackage

// File: rtl/instruction_scheduler_pkg.sv
// Types, sizes and pointer arithmetic for the scheduler-to-PE issue path.
package instruction_scheduler_pkg;
  localparam int PE_ID_W         = 4;
  localparam int PE_MAX_INFLIGHT = 16;
  localparam int PE_INFLIGHT_W   = $clog2(PE_MAX_INFLIGHT) + 1;
  localparam int PE_PTR_MAX_W    = 16;

  typedef logic [PE_ID_W-1:0] pe_issue_id_t;

  // Modulo difference of two wrap-bit pointers that are w bits wide.
  function automatic logic [PE_PTR_MAX_W-1:0] ptr_diff(input logic [PE_PTR_MAX_W-1:0] a,
                                                       input logic [PE_PTR_MAX_W-1:0] b,
                                                       input int unsigned w);
    logic [PE_PTR_MAX_W-1:0] mask;
    mask = (PE_PTR_MAX_W'(1) << w) - PE_PTR_MAX_W'(1);
    return (a - b) & mask;
  endfunction
endpackage

// File: rtl/pe_issue_id_ring.sv
// ID ring: one write port at issue, read ports at the rd/wr completion pointers.
module pe_issue_id_ring
  import instruction_scheduler_pkg::*;
#(
  parameter  int ID_W  = PE_ID_W,
  parameter  int DEPTH = PE_MAX_INFLIGHT,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            s_rst,
  input  logic            iss_en,
  input  logic [ID_W-1:0] iss_id,
  input  logic            rd_adv,
  input  logic            wr_adv,
  output logic [ID_W-1:0] rd_id,
  output logic [ID_W-1:0] wr_id,
  output logic [PW-1:0]   n_rd,
  output logic [PW-1:0]   n_wr,
  output logic [PW-1:0]   n_tot
);
  localparam int IW = PW - 1;

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]   iss_ptr_q, iss_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  always_comb begin
    mem_d     = mem_q;
    iss_ptr_d = iss_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (iss_en) begin
      mem_d[iss_ptr_q[IW-1:0]] = iss_id;
      iss_ptr_d                = iss_ptr_q + PW'(1);
    end
    if (rd_adv) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_adv) wr_ptr_d = wr_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      iss_ptr_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      iss_ptr_q <= iss_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Entries are only read between their write and retirement, so no reset.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign rd_id = mem_q[rd_ptr_q[IW-1:0]];
  assign wr_id = mem_q[wr_ptr_q[IW-1:0]];
  assign n_rd  = PW'(ptr_diff(PE_PTR_MAX_W'(iss_ptr_q), PE_PTR_MAX_W'(rd_ptr_q), PW));
  assign n_wr  = PW'(ptr_diff(PE_PTR_MAX_W'(rd_ptr_q), PE_PTR_MAX_W'(wr_ptr_q), PW));
  assign n_tot = PW'(ptr_diff(PE_PTR_MAX_W'(iss_ptr_q), PE_PTR_MAX_W'(wr_ptr_q), PW));
endmodule

// File: rtl/pe_issue_tracker.sv
// Issues tagged instructions to the PE through one output register and tracks
// each through its rd/wr completion acks, reporting completed IDs back.
module pe_issue_tracker
  import hpu_common_instruction_pkg::*;
  import instruction_scheduler_pkg::*;
#(
  parameter  int INSN_W       = PE_INST_W,
  parameter  int ID_W         = $bits(pe_issue_id_t),
  parameter  int MAX_INFLIGHT = PE_MAX_INFLIGHT,
  localparam int CW           = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic [INSN_W-1:0] in_insn,
  input  logic [ID_W-1:0]   in_id,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [INSN_W-1:0] pe_insn,
  output logic              pe_vld,
  input  logic              pe_rdy,
  input  logic              pe_rd_ack,
  input  logic              pe_wr_ack,
  output logic              rd_done_vld,
  output logic [ID_W-1:0]   rd_done_id,
  output logic              wr_done_vld,
  output logic [ID_W-1:0]   wr_done_id,
  output logic [CW-1:0]     inflight_cnt,
  output logic              idle,
  output logic              err_ack
);
  logic              pe_vld_q, pe_vld_d;
  logic [INSN_W-1:0] pe_insn_q, pe_insn_d;
  logic [ID_W-1:0]   stg_id_q, stg_id_d;
  logic              rd_done_vld_q, rd_done_vld_d;
  logic [ID_W-1:0]   rd_done_id_q, rd_done_id_d;
  logic              wr_done_vld_q, wr_done_vld_d;
  logic [ID_W-1:0]   wr_done_id_q, wr_done_id_d;
  logic              err_q, err_d;

  logic [ID_W-1:0] ring_rd_id, ring_wr_id;
  logic [CW-1:0]   n_rd, n_wr, n_tot;
  logic            hs, load, rd_ok, wr_ok;

  assign hs           = pe_vld_q && pe_rdy;
  assign inflight_cnt = n_tot + CW'(pe_vld_q);
  assign in_rdy       = (!pe_vld_q || pe_rdy) && (inflight_cnt < CW'(MAX_INFLIGHT));
  assign load         = in_vld && in_rdy;
  // Counts are start-of-cycle, so same-cycle handover or rd->wr moves stay illegal.
  assign rd_ok        = pe_rd_ack && (n_rd != '0);
  assign wr_ok        = pe_wr_ack && (n_wr != '0);

  pe_issue_id_ring #(.ID_W(ID_W), .DEPTH(MAX_INFLIGHT)) u_ring (
    .clk    (clk),
    .s_rst  (s_rst),
    .iss_en (hs),
    .iss_id (stg_id_q),
    .rd_adv (rd_ok),
    .wr_adv (wr_ok),
    .rd_id  (ring_rd_id),
    .wr_id  (ring_wr_id),
    .n_rd   (n_rd),
    .n_wr   (n_wr),
    .n_tot  (n_tot)
  );

  always_comb begin
    pe_vld_d      = pe_vld_q;
    pe_insn_d     = pe_insn_q;
    stg_id_d      = stg_id_q;
    rd_done_vld_d = rd_ok;
    rd_done_id_d  = rd_ok ? ring_rd_id : rd_done_id_q;
    wr_done_vld_d = wr_ok;
    wr_done_id_d  = wr_ok ? ring_wr_id : wr_done_id_q;
    err_d         = err_q || (pe_rd_ack && !rd_ok) || (pe_wr_ack && !wr_ok);
    if (load) begin
      pe_vld_d  = 1'b1;
      pe_insn_d = in_insn;
      stg_id_d  = in_id;
    end else if (hs) begin
      pe_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      pe_vld_q      <= 1'b0;
      pe_insn_q     <= '0;
      stg_id_q      <= '0;
      rd_done_vld_q <= 1'b0;
      rd_done_id_q  <= '0;
      wr_done_vld_q <= 1'b0;
      wr_done_id_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      pe_vld_q      <= pe_vld_d;
      pe_insn_q     <= pe_insn_d;
      stg_id_q      <= stg_id_d;
      rd_done_vld_q <= rd_done_vld_d;
      rd_done_id_q  <= rd_done_id_d;
      wr_done_vld_q <= wr_done_vld_d;
      wr_done_id_q  <= wr_done_id_d;
      err_q         <= err_d;
    end
  end

  assign pe_vld      = pe_vld_q;
  assign pe_insn     = pe_insn_q;
  assign rd_done_vld = rd_done_vld_q;
  assign rd_done_id  = rd_done_id_q;
  assign wr_done_vld = wr_done_vld_q;
  assign wr_done_id  = wr_done_id_q;
  assign idle        = (inflight_cnt == '0);
  assign err_ack     = err_q;
endmodule
